// File: rtl/mem_burst_pkg.sv
// Shared definitions for the burst master: FSM state encoding, command op
// encoding and the default bus geometry used by the interface and modules.
package mem_burst_pkg;

    localparam int unsigned DEFAULT_AW    = 8;
    localparam int unsigned DEFAULT_DW    = 8;
    localparam int unsigned DEFAULT_DEPTH = 32;
    localparam int unsigned DEFAULT_LENW  = 6;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = IDLE,
        StWrite = WRITE,
        StRead  = READ,
        StDrain = DRAIN,
        StDone  = DONE
    } state_e;

    typedef enum logic {
        OpRead  = 1'b0,
        OpWrite = 1'b1
    } op_e;

endpackage

// File: rtl/mem_burst_master_if.sv
// Bus bundle for mem_burst_master.
//   Command stream : CmdValid/CmdReady, CmdWrite, CmdAddr, CmdLen
//   Write stream   : WrValid/WrReady, WrData
//   Read stream    : RdValid/RdReady, RdData
//   Status         : Busy, Done, Error
//   Memory port    : Address, WriteData, MemRead, MemWrite, ReadData
// Modport master is the burst engine's view; slave is the front end / memory view.
interface mem_burst_master_if #(
    parameter int unsigned AW   = mem_burst_pkg::DEFAULT_AW,
    parameter int unsigned DW   = mem_burst_pkg::DEFAULT_DW,
    parameter int unsigned LENW = mem_burst_pkg::DEFAULT_LENW
) ();

    logic            CmdValid;
    logic            CmdReady;
    logic            CmdWrite;
    logic [AW-1:0]   CmdAddr;
    logic [LENW-1:0] CmdLen;

    logic            WrValid;
    logic            WrReady;
    logic [DW-1:0]   WrData;

    logic            RdValid;
    logic            RdReady;
    logic [DW-1:0]   RdData;

    logic            Busy;
    logic            Done;
    logic            Error;

    logic [AW-1:0]   Address;
    logic [DW-1:0]   WriteData;
    logic            MemRead;
    logic            MemWrite;
    logic [DW-1:0]   ReadData;

    modport master (
        input  CmdValid, CmdWrite, CmdAddr, CmdLen,
        input  WrValid, WrData,
        input  RdReady,
        input  ReadData,
        output CmdReady, WrReady, RdValid, RdData,
        output Busy, Done, Error,
        output Address, WriteData, MemRead, MemWrite
    );

    modport slave (
        output CmdValid, CmdWrite, CmdAddr, CmdLen,
        output WrValid, WrData,
        output RdReady,
        output ReadData,
        input  CmdReady, WrReady, RdValid, RdData,
        input  Busy, Done, Error,
        input  Address, WriteData, MemRead, MemWrite
    );

endinterface

// File: rtl/mem_burst_addr_ctr.sv
// Burst address pointer and remaining-beat counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : capture load_ptr / load_cnt (takes priority over step)
//   step         : advance ptr (wrapping modulo DEPTH) and decrement cnt
//   ptr, cnt     : current address pointer and beats remaining
//   last         : cnt == 1, i.e. the beat being stepped now is the final one
module mem_burst_addr_ctr
    import mem_burst_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned LENW  = DEFAULT_LENW,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            step,
    input  logic [PW-1:0]   load_ptr,
    input  logic [LENW-1:0] load_cnt,
    output logic [PW-1:0]   ptr,
    output logic [LENW-1:0] cnt,
    output logic            last
);

    logic [PW-1:0]   ptr_q;
    logic [LENW-1:0] cnt_q;

    // DEPTH is a power of two, so PW-bit overflow is exactly the wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            ptr_q <= load_ptr;
            cnt_q <= load_cnt;
        end else if (step) begin
            ptr_q <= ptr_q + PW'(1);
            cnt_q <= cnt_q - LENW'(1);
        end
    end

    assign ptr  = ptr_q;
    assign cnt  = cnt_q;
    assign last = (cnt_q == LENW'(1));

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port data memory. One command (op, base
// address, beat count) becomes a burst of consecutive accesses; write data
// arrives on the WrValid/WrReady stream and read data leaves on the
// registered RdValid/RdReady stream.
//   clk     : clock, all state on posedge
//   reset_n : asynchronous active-low reset; aborts any burst in flight
//   bus     : mem_burst_master_if.master (command, write, read, status, memory)
// Optional build macro ADDR_CHECK_EN: a command whose CmdAddr >= DEPTH makes no
// memory access and finishes with Error pulsed alongside Done. Without it
// Error is tied low and CmdAddr is taken modulo DEPTH.
module mem_burst_master
    import mem_burst_pkg::*;
#(
    parameter int unsigned AW    = DEFAULT_AW,
    parameter int unsigned DW    = DEFAULT_DW,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned LENW  = DEFAULT_LENW
) (
    input logic                clk,
    input logic                reset_n,
    mem_burst_master_if.master bus
);

    localparam int unsigned PW = $clog2(DEPTH);

    state_e          state_q;
    logic            rd_valid_q;
    logic [DW-1:0]   rd_data_q;
    logic            err_q;

    logic [PW-1:0]   ptr;
    logic [LENW-1:0] cnt;
    logic            last;

    logic            addr_bad;
    logic            cmd_take;
    logic            wr_beat;
    logic            rd_issue;
    logic            rd_accept;
    op_e             cmd_op;

    assign cmd_op    = op_e'(bus.CmdWrite);
    assign cmd_take  = (state_q == StIdle) && bus.CmdValid;
    assign wr_beat   = (state_q == StWrite) && bus.WrValid;
    assign rd_accept = rd_valid_q && bus.RdReady;
    // A new read may only be issued when the output register is free or is
    // being emptied in this same cycle.
    assign rd_issue  = (state_q == StRead) && (cnt != '0) && (!rd_valid_q || bus.RdReady);

    mem_burst_addr_ctr #(
        .DEPTH (DEPTH),
        .LENW  (LENW)
    ) u_addr_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cmd_take),
        .step     (wr_beat || rd_issue),
        .load_ptr (bus.CmdAddr[PW-1:0]),
        .load_cnt (bus.CmdLen),
        .ptr      (ptr),
        .cnt      (cnt),
        .last     (last)
    );

`ifdef ADDR_CHECK_EN
    assign addr_bad  = |bus.CmdAddr[AW-1:PW];
    assign bus.Error = (state_q == StDone) && err_q;
`else
    assign addr_bad  = 1'b0;
    assign bus.Error = 1'b0;
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.CmdAddr[AW-1:PW], err_q};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    err_q <= 1'b0;
                    if (bus.CmdValid) begin
                        if (addr_bad) begin
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else if (bus.CmdLen == '0) begin
                            state_q <= StDone;
                        end else if (cmd_op == OpWrite) begin
                            state_q <= StWrite;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StWrite: begin
                    if (wr_beat && last) begin
                        state_q <= StDone;
                    end
                end
                StRead: begin
                    if (rd_issue) begin
                        rd_data_q  <= bus.ReadData;
                        rd_valid_q <= 1'b1;
                        if (last) begin
                            state_q <= StDrain;
                        end
                    end else if (rd_accept) begin
                        rd_valid_q <= 1'b0;
                    end
                end
                StDrain: begin
                    if (rd_accept) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.CmdReady  = (state_q == StIdle);
    assign bus.WrReady   = (state_q == StWrite);
    assign bus.RdValid   = rd_valid_q;
    assign bus.RdData    = rd_data_q;
    assign bus.Busy      = (state_q != StIdle);
    assign bus.Done      = (state_q == StDone);
    assign bus.Address   = AW'(ptr);
    assign bus.WriteData = (state_q == StWrite) ? bus.WrData : '0;
    assign bus.MemRead   = rd_issue;
    assign bus.MemWrite  = wr_beat;

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master: a 32-word memory device, directed
// bursts followed by randomized bursts, compared against a word-level model.
module tb_mem_burst_master;

`ifdef ADDR_CHECK_EN
    localparam bit AddrCheck = 1'b1;
`else
    localparam bit AddrCheck = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_burst_master_if bus ();

    mem_burst_master dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Memory device driven by the DUT's memory port.
    logic [7:0] dev_mem [32];
    bit         mem_loaded = 1'b0;

    function automatic logic [7:0] init_word(input int i);
        if (i == 30) return 8'hF2;
        if (i == 31) return 8'hF1;
        return 8'(i);
    endfunction

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) dev_mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (bus.MemWrite) begin
            dev_mem[bus.Address[4:0]] <= bus.WriteData;
        end
    end

    assign bus.ReadData = dev_mem[bus.Address[4:0]];

    // Reference memory image, updated by the model from burst semantics.
    logic [7:0] ref_mem [32];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Per-burst observation logs.
    logic [15:0] wr_log [$];
    logic [7:0]  rd_log [$];
    logic [7:0]  rd_got [$];
    int          done_cnt, err_cnt, rb_bad, hold_bad, both_bad, wd_bad;
    logic        prev_rv;
    logic [7:0]  prev_rd;

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        rd_got.delete();
        done_cnt = 0; err_cnt = 0; rb_bad = 0; hold_bad = 0; both_bad = 0; wd_bad = 0;
    endtask

    // Called at negedge before inputs change: registered/state outputs.
    task automatic sample_regs();
        if (prev_rv && bus.RdReady) rd_got.push_back(prev_rd);
        if (prev_rv && !bus.RdReady && (!bus.RdValid || bus.RdData !== prev_rd)) hold_bad++;
        prev_rv = bus.RdValid;
        prev_rd = bus.RdData;
        if (bus.Done) done_cnt++;
        if (bus.Error) err_cnt++;
        if (bus.CmdReady === bus.Busy) rb_bad++;
    endtask

    // Called 1 time unit after inputs change: memory accesses that the next posedge performs.
    task automatic log_comb();
        if (bus.MemRead && bus.MemWrite) both_bad++;
        if (bus.MemWrite) wr_log.push_back({bus.Address, bus.WriteData});
        if (bus.MemRead) rd_log.push_back(bus.Address);
        if (!bus.WrReady && bus.WriteData !== 8'h00) wd_bad++;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_cmd_ready"}, bus.CmdReady, 1);
        check_eq({pfx, "_busy"},      bus.Busy, 0);
        check_eq({pfx, "_done"},      bus.Done, 0);
        check_eq({pfx, "_error"},     bus.Error, 0);
        check_eq({pfx, "_mem_read"},  bus.MemRead, 0);
        check_eq({pfx, "_mem_write"}, bus.MemWrite, 0);
        check_eq({pfx, "_wdata"},     bus.WriteData, 0);
        check_eq({pfx, "_address"},   bus.Address, 0);
        check_eq({pfx, "_rd_valid"},  bus.RdValid, 0);
        check_eq({pfx, "_rd_data"},   bus.RdData, 0);
        check_eq({pfx, "_wr_ready"},  bus.WrReady, 0);
    endtask

    task automatic burst(input bit wr, input logic [7:0] addr, input int len,
                         input bit rnd, input bit fixed);
        logic [7:0] wdata [$];
        int         exp_addr [$];
        logic [7:0] exp_rd [$];
        bit         bad;
        int         base, wi, cyc, done_at, exp_lat, exp_nw, exp_nr;
        logic [1:0] final_status;

        bad  = AddrCheck && (addr >= 8'd32);
        base = int'(addr) % 32;
        for (int i = 0; i < len; i++) wdata.push_back(fixed ? 8'(8'hAA + 17 * i) : 8'($urandom));
        if (!bad) begin
            for (int i = 0; i < len; i++) exp_addr.push_back((base + i) % 32);
        end
        if (!wr) begin
            foreach (exp_addr[i]) exp_rd.push_back(ref_mem[exp_addr[i]]);
        end
        clear_logs();
        prev_rv = 1'b0;
        final_status = 2'b00;

        @(negedge clk);
        check_eq("cmd_ready_idle", bus.CmdReady, 1);
        bus.CmdValid = 1'b1;
        bus.CmdWrite = wr;
        bus.CmdAddr  = addr;
        bus.CmdLen   = 6'(len);
        bus.WrValid  = rnd ? 1'($urandom) : 1'b0;
        bus.WrData   = 8'($urandom);
        bus.RdReady  = rnd ? 1'($urandom) : 1'b1;
        #1 log_comb();

        wi = 0; cyc = 0; done_at = -1;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            sample_regs();
            if (bus.Done && done_at < 0) done_at = cyc;
            if (done_at >= 0 && cyc == done_at + 1) begin
                final_status = {bus.Busy, bus.CmdReady};
                break;
            end
            // Junk commands while busy must be ignored.
            bus.CmdValid = (done_at < 0 && rnd) ? 1'($urandom) : 1'b0;
            bus.CmdWrite = 1'($urandom);
            bus.CmdAddr  = 8'($urandom);
            bus.CmdLen   = 6'($urandom);
            if (wr && wi < len) begin
                bus.WrValid = rnd ? 1'($urandom) : 1'b1;
                bus.WrData  = wdata[wi];
            end else begin
                bus.WrValid = rnd ? 1'($urandom) : 1'b0;
                bus.WrData  = 8'($urandom);
            end
            if (bus.WrValid && bus.WrReady) wi++;
            bus.RdReady = rnd ? 1'($urandom) : 1'b1;
            #1 log_comb();
        end
        bus.CmdValid = 1'b0;
        bus.WrValid  = 1'b0;
        bus.RdReady  = 1'b0;

        if (wr && !bad) begin
            for (int i = 0; i < len; i++) ref_mem[(base + i) % 32] = wdata[i];
        end

        exp_lat = (len == 0 || bad) ? 1 : (wr ? len + 1 : len + 2);
        exp_nw  = wr ? exp_addr.size() : 0;
        exp_nr  = wr ? 0 : exp_addr.size();

        check_eq("done_timeout", (done_at < 0), 0);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("error_pulses", err_cnt, bad);
        if (!rnd) check_eq("done_latency", done_at, exp_lat);
        check_eq("idle_after_done", final_status, 2'b01);
        check_eq("ready_vs_busy", rb_bad, 0);
        check_eq("rd_hold", hold_bad, 0);
        check_eq("rd_wr_both", both_bad, 0);
        check_eq("wdata_outside_write", wd_bad, 0);
        check_eq("n_writes", wr_log.size(), exp_nw);
        check_eq("n_reads", rd_log.size(), exp_nr);
        check_eq("n_rd_beats", rd_got.size(), exp_nr);
        if (wr && wr_log.size() == exp_nw) begin
            foreach (wr_log[i]) begin
                check_eq($sformatf("wr_addr[%0d]", i), wr_log[i][15:8], exp_addr[i]);
                check_eq($sformatf("wr_data[%0d]", i), wr_log[i][7:0], wdata[i]);
            end
        end
        if (!wr && rd_log.size() == exp_nr && rd_got.size() == exp_nr) begin
            foreach (rd_log[i]) begin
                check_eq($sformatf("rd_addr[%0d]", i), rd_log[i], exp_addr[i]);
                check_eq($sformatf("rd_beat[%0d]", i), rd_got[i], exp_rd[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d [3];
        int         mism;

        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
        bus.CmdValid = 1'b0;
        bus.CmdWrite = 1'b0;
        bus.CmdAddr  = '0;
        bus.CmdLen   = '0;
        bus.WrValid  = 1'b0;
        bus.WrData   = '0;
        bus.RdReady  = 1'b0;
        prev_rv      = 1'b0;
        prev_rd      = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;

        burst(1'b1, 8'd4, 3, 1'b0, 1'b1);   // AA, BB, CC at 4..6
        burst(1'b0, 8'd0, 4, 1'b0, 1'b0);   // 00..03 back to back
        burst(1'b0, 8'd30, 4, 1'b1, 1'b0);  // wrap 30,31,0,1 with stalls
        burst(1'b1, 8'd3, 0, 1'b1, 1'b0);   // no-op write
        burst(1'b0, 8'd9, 0, 1'b0, 1'b0);   // no-op read
        burst(1'b0, 8'd2, 6, 1'b0, 1'b0);   // sees the earlier write

        // Abort a 5-beat write after two accepted beats.
        for (int i = 0; i < 3; i++) d[i] = 8'($urandom_range(1, 255));
        @(negedge clk);
        bus.CmdValid = 1'b1; bus.CmdWrite = 1'b1; bus.CmdAddr = 8'd10; bus.CmdLen = 6'd5;
        @(negedge clk);
        bus.CmdValid = 1'b0; bus.WrValid = 1'b1; bus.WrData = d[0];
        @(negedge clk);
        bus.WrData = d[1];
        @(negedge clk);
        bus.WrData = d[2];
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        bus.WrValid = 1'b0;
        reset_n = 1'b1;
        prev_rv = 1'b0;
        ref_mem[10] = d[0];
        ref_mem[11] = d[1];
        burst(1'b0, 8'd9, 5, 1'b0, 1'b0);   // 9..13: only 10,11 changed

        burst(1'b1, 8'd40, 3, 1'b0, 1'b0);  // rejected, or 8..10 when unchecked
        burst(1'b0, 8'd40, 3, 1'b0, 1'b0);
        burst(1'b1, 8'd28, 40, 1'b0, 1'b0); // longer than memory, wraps twice
        burst(1'b0, 8'd0, 32, 1'b1, 1'b0);

        for (int n = 0; n < 24; n++) begin
            burst(1'($urandom), 8'($urandom_range(0, 47)), $urandom_range(0, 40),
                  1'($urandom), 1'b0);
        end

        @(negedge clk);
        mism = 0;
        for (int i = 0; i < 32; i++) if (dev_mem[i] !== ref_mem[i]) mism++;
        check_eq("mem_image", mism, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
